// File: rtl/parking_pkg.sv
// Shared types and helpers for the multi-lane parking occupancy counter.
package parking_pkg;

  // Lane sequence decoder states; entry path is a -> a+b -> b, exit path mirrors it.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ENT_A  = 3'd1,
    ENT_AB = 3'd2,
    ENT_B  = 3'd3,
    EXT_B  = 3'd4,
    EXT_BA = 3'd5,
    EXT_A  = 3'd6
  } lane_state_e;

  localparam int MAX_LANES = 8;

  // Number of set bits in an up-to-eight-lane pulse vector.
  function automatic logic [3:0] popcount8(input logic [MAX_LANES-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/parking_lane_decoder.sv
// One gate lane: synchronise and debounce both beams, then decode the beam
// order into registered one-cycle entry/exit pulses.
//
// state  | meaning
// IDLE   | no vehicle in the gate
// ENT_A  | outer beam broken, heading in
// ENT_AB | both beams broken on the way in
// ENT_B  | only inner beam broken; clearing completes an entry
// EXT_B  | inner beam broken, heading out
// EXT_BA | both beams broken on the way out
// EXT_A  | only outer beam broken; clearing completes an exit
module parking_lane_decoder
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sens_a_i,
  input  logic sens_b_i,
  output logic entry_pulse_o,
  output logic exit_pulse_o
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Index 0 is the outer beam (a), index 1 the inner beam (b).
  logic [1:0]      raw;
  logic [1:0]      sync1_q;
  logic [1:0]      sync2_q;
  logic [1:0]      deb_q;
  logic [1:0]      deb_d;
  logic [DB_W-1:0] cnt_q [2];
  logic [DB_W-1:0] cnt_d [2];

  lane_state_e state_q;
  lane_state_e state_d;
  logic        entry_q;
  logic        entry_d;
  logic        exit_q;
  logic        exit_d;
  logic        a;
  logic        b;

  assign raw = {sens_b_i, sens_a_i};

  // Two-flop synchroniser for the raw beams, which are asynchronous to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: a beam only changes after staying at its new level long enough.
  always_comb begin
    deb_d    = deb_q;
    cnt_d[0] = '0;
    cnt_d[1] = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          deb_d[i] = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q    <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      deb_q    <= deb_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  assign a = deb_q[0];
  assign b = deb_q[1];

  // Sequence decoder next state; a pulse is raised only when a full
  // sequence clears, so aborts and back-outs never count.
  always_comb begin
    state_d = state_q;
    entry_d = 1'b0;
    exit_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Both beams rising together gives no direction, so it is ignored.
        if (a && !b)      state_d = ENT_A;
        else if (!a && b) state_d = EXT_B;
      end
      ENT_A: begin
        if (b)       state_d = ENT_AB;
        else if (!a) state_d = IDLE;
      end
      ENT_AB: begin
        if (!a && b)       state_d = ENT_B;
        else if (a && !b)  state_d = ENT_A;
        else if (!a && !b) state_d = IDLE;
      end
      ENT_B: begin
        if (a) begin
          state_d = ENT_AB;
        end else if (!b) begin
          state_d = IDLE;
          entry_d = 1'b1;
        end
      end
      EXT_B: begin
        if (a)       state_d = EXT_BA;
        else if (!b) state_d = IDLE;
      end
      EXT_BA: begin
        if (a && !b)       state_d = EXT_A;
        else if (!a && b)  state_d = EXT_B;
        else if (!a && !b) state_d = IDLE;
      end
      EXT_A: begin
        if (b) begin
          state_d = EXT_BA;
        end else if (!a) begin
          state_d = IDLE;
          exit_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decoder state and registered pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      entry_q <= 1'b0;
      exit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      exit_q  <= exit_d;
    end
  end

  assign entry_pulse_o = entry_q;
  assign exit_pulse_o  = exit_q;

endmodule

// File: rtl/parking_lane_counter.sv
// Lot-wide occupancy counter fed by N_LANES gate decoders. Entries and exits
// from all lanes in one cycle are netted before saturating at 0..CAPACITY.
module parking_lane_counter
  import parking_pkg::*;
#(
  parameter int N_LANES         = 2,
  parameter int CAPACITY        = 200,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = $clog2(CAPACITY + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_LANES-1:0] sens_a,
  input  logic [N_LANES-1:0] sens_b,
  output logic [N_LANES-1:0] entry_pulse,
  output logic [N_LANES-1:0] exit_pulse,
  output logic [CNT_W-1:0]   occupancy,
  output logic [CNT_W-1:0]   free_spaces,
  output logic               full,
  output logic               empty,
  output logic               overflow_err,
  output logic               underflow_err
);

  // Four extra bits hold the signed sum of the count and up to eight pulses.
  localparam int SUM_W = CNT_W + 4;
  localparam logic [CNT_W-1:0]        CAP_C = CNT_W'(CAPACITY);
  localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);

  logic [3:0]              e_cnt;
  logic [3:0]              x_cnt;
  logic signed [SUM_W-1:0] sum;
  logic [CNT_W-1:0]        occ_q;
  logic [CNT_W-1:0]        occ_d;
  logic                    ovf_q;
  logic                    ovf_d;
  logic                    unf_q;
  logic                    unf_d;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    parking_lane_decoder #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clk          (clk),
      .reset_n      (reset_n),
      .sens_a_i     (sens_a[g]),
      .sens_b_i     (sens_b[g]),
      .entry_pulse_o(entry_pulse[g]),
      .exit_pulse_o (exit_pulse[g])
    );
  end

  // Net this cycle's entries against exits, then saturate and flag the loss.
  always_comb begin
    e_cnt = popcount8(MAX_LANES'(entry_pulse));
    x_cnt = popcount8(MAX_LANES'(exit_pulse));
    sum   = $signed({4'b0000, occ_q}) + $signed(SUM_W'(e_cnt)) - $signed(SUM_W'(x_cnt));
    occ_d = sum[CNT_W-1:0];
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (sum < 0) begin
      occ_d = '0;
      unf_d = 1'b1;
    end else if (sum > CAP_S) begin
      occ_d = CAP_C;
      ovf_d = 1'b1;
    end
  end

  // Occupancy register and the error pulses that accompany each update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign occupancy     = occ_q;
  assign free_spaces   = CAP_C - occ_q;
  assign full          = (occ_q == CAP_C);
  assign empty         = (occ_q == '0);
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule
